// File: rtl/catgame_pkg.sv
// Shared types and default constants for the CatTrap push-button front end.
package catgame_pkg;

  // Per-channel debounce/auto-repeat state
  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PULSE,
    HOLD,
    REPEAT,
    DB_RELEASE
  } btn_state_t;

  // Event outputs decoded from a channel state
  typedef struct packed {
    logic lvl;
    logic press;
    logic rpt;
  } btn_evt_t;

  // Defaults for a 100 MHz board clock
  localparam int DEF_NUM_BTNS        = 5;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 20_000_000;
  localparam int DEF_CNT_W           = 26;

  // Button bit positions on the btn_* buses
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  // Moore decode: the game FSM only ever sees these three qualified events
  function automatic btn_evt_t btn_decode(input btn_state_t s);
    btn_evt_t e;
    e.press = (s == PULSE);
    e.rpt   = (s == PULSE) || (s == REPEAT);
    e.lvl   = (s == PULSE) || (s == HOLD) || (s == REPEAT) || (s == DB_RELEASE);
    return e;
  endfunction

endpackage

// File: rtl/btn_debounce_pulser_if.sv
// Button bus: raw pins in, debounced level / press / repeat events out.
interface btn_debounce_pulser_if #(
  parameter int NUM_BTNS = catgame_pkg::DEF_NUM_BTNS
);
  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_level;
  logic [NUM_BTNS-1:0] btn_press;
  logic [NUM_BTNS-1:0] btn_repeat;

  // Board / stimulus side drives the pins and consumes the events
  modport master (output btn_raw, input btn_level, btn_press, btn_repeat);
  // Debouncer side
  modport slave  (input btn_raw, output btn_level, btn_press, btn_repeat);
endinterface

// File: rtl/btn_debounce_pulser_channel.sv
// One button channel: 2-flop synchroniser, debounce/auto-repeat FSM, shared counter.
module btn_channel
  import catgame_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic repeat_o
);

  // Terminal counts; each state compares before incrementing so cnt never wraps
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       sync1_q, sync2_q;
  btn_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       rep_q, rep_d;
  btn_evt_t   evt;

  // Synchronise the asynchronous pin; the FSM only looks at sync2_q
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // State, counter and first-repeat-done flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
    end
  end

  // Next-state logic; pin level checks take priority over terminal counts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sync2_q) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!sync2_q)            state_d = IDLE;
        else if (cnt_q == DB_LAST) state_d = PULSE;
        else                     cnt_d = cnt_q + CNT_ONE;
      end
      PULSE: begin
        state_d = HOLD;
        cnt_d   = '0;
        rep_d   = 1'b0;
      end
      HOLD: begin
        if (!sync2_q) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == (rep_q ? RP_LAST : RD_LAST)) begin
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REPEAT: begin
        state_d = HOLD;
        cnt_d   = '0;
        rep_d   = 1'b1;
      end
      DB_RELEASE: begin
        // A short glitch low returns to HOLD with the repeat timer restarted
        if (sync2_q) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          rep_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        rep_d   = 1'b0;
      end
    endcase
  end

  assign evt      = btn_decode(state_q);
  assign level_o  = evt.lvl;
  assign press_o  = evt.press;
  assign repeat_o = evt.rpt;

endmodule

// File: rtl/btn_debounce_pulser.sv
// Push-button front end: NUM_BTNS independent debounce/auto-repeat channels.
module btn_debounce_pulser
  import catgame_pkg::*;
#(
  parameter int NUM_BTNS        = DEF_NUM_BTNS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic              ClkPort,
  input logic              Reset,
  btn_debounce_pulser_if.slave btn
);

  logic [NUM_BTNS-1:0] lvl, prs, rpt;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk_i    (ClkPort),
      .rst_i    (Reset),
      .raw_i    (btn.btn_raw[i]),
      .level_o  (lvl[i]),
      .press_o  (prs[i]),
      .repeat_o (rpt[i])
    );
  end

  assign btn.btn_level  = lvl;
  assign btn.btn_press  = prs;
  assign btn.btn_repeat = rpt;

endmodule

// File: tb/tb_btn_debounce_pulser.sv
// Bench for btn_debounce_pulser with short timing constants.
module tb_btn_debounce_pulser;
  localparam int NB = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int CW = 8;

  logic ClkPort = 1'b0;
  logic Reset   = 1'b1;

  btn_debounce_pulser_if #(.NUM_BTNS(NB)) bif ();

  btn_debounce_pulser #(
    .NUM_BTNS(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .btn     (bif.slave)
  );

  always #5 ClkPort = ~ClkPort;

  int n_vec = 0;
  int n_err = 0;
  int gk    = 0;

  // Reference model: event-based view of the button rules
  bit m_s1[NB], m_s2[NB];
  bit m_pressed[NB], m_rep_done[NB];
  int m_ones[NB], m_zeros[NB], m_next_rep[NB], m_ignore[NB];
  logic [NB-1:0] exp_lvl, exp_prs, exp_rpt;

  typedef struct {
    logic [NB-1:0] raw;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rpt;
  } vec_t;
  vec_t tbl[22];

  int exp_rep3[5] = '{7, 18, 24, 30, 36};
  int exp_rep4[3] = '{7, 27, 33};
  int q_prs[$];
  int q_rep[$];

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      m_s1[c] = 0; m_s2[c] = 0; m_pressed[c] = 0; m_rep_done[c] = 0;
      m_ones[c] = 0; m_zeros[c] = 0; m_next_rep[c] = -1; m_ignore[c] = -1;
    end
    exp_lvl = '0; exp_prs = '0; exp_rpt = '0;
  endtask

  // Press accepted after DB+1 consecutive high samples; release after DB+1 low samples;
  // repeats fall due at fixed offsets from the last (re)entry into the held phase.
  task automatic model_edge(input logic [NB-1:0] raw);
    bit samp;
    for (int c = 0; c < NB; c++) begin
      samp = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
      exp_prs[c] = 1'b0;
      exp_rpt[c] = 1'b0;
      if (!m_pressed[c]) begin
        m_ones[c] = samp ? m_ones[c] + 1 : 0;
        if (m_ones[c] == DB + 1) begin
          m_pressed[c] = 1; m_rep_done[c] = 0; m_zeros[c] = 0;
          exp_prs[c] = 1'b1; exp_rpt[c] = 1'b1;
          m_next_rep[c] = gk + 1 + RD;
          m_ignore[c] = gk + 1;
        end
      end else if (gk == m_ignore[c]) begin
        // single-cycle event slot, pin not looked at
      end else if (m_zeros[c] > 0) begin
        if (samp) begin
          m_zeros[c] = 0;
          m_next_rep[c] = gk + (m_rep_done[c] ? RP : RD);
        end else begin
          m_zeros[c]++;
          if (m_zeros[c] == DB + 1) begin
            m_pressed[c] = 0; m_rep_done[c] = 0; m_ones[c] = 0; m_zeros[c] = 0;
          end
        end
      end else if (!samp) begin
        m_zeros[c] = 1;
      end else if (gk == m_next_rep[c]) begin
        exp_rpt[c] = 1'b1;
        m_rep_done[c] = 1;
        m_next_rep[c] = gk + 1 + RP;
        m_ignore[c] = gk + 1;
      end
      exp_lvl[c] = m_pressed[c];
    end
  endtask

  // One clock: advance the model on the edge, compare just after it
  task automatic step();
    @(posedge ClkPort);
    gk++;
    if (Reset) model_reset();
    else       model_edge(bif.btn_raw);
    #1;
    chk("model_level",  bif.btn_level,  exp_lvl);
    chk("model_press",  bif.btn_press,  exp_prs);
    chk("model_repeat", bif.btn_repeat, exp_rpt);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bif.btn_raw = '0;
    repeat (3) step();
    Reset = 1'b0;
  endtask

  initial begin
    logic pat [8];
    int   r_left [NB];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 22; i++) begin
      int e;
      e = i + 1;
      tbl[i].raw = (e <= 12) ? NB'(1) : '0;
      tbl[i].lvl = (e >= 7 && e <= 18) ? NB'(1) : '0;
      tbl[i].prs = (e == 7) ? NB'(1) : '0;
      tbl[i].rpt = (e == 7) ? NB'(1) : '0;
    end

    bif.btn_raw = '0;
    model_reset();
    #1;
    chk("reset_level",  bif.btn_level,  '0);
    chk("reset_press",  bif.btn_press,  '0);
    chk("reset_repeat", bif.btn_repeat, '0);
    do_reset();

    // 1: clean press, table driven
    for (int i = 0; i < 22; i++) begin
      bif.btn_raw = tbl[i].raw;
      step();
      chk("t1_level",  bif.btn_level,  tbl[i].lvl);
      chk("t1_press",  bif.btn_press,  tbl[i].prs);
      chk("t1_repeat", bif.btn_repeat, tbl[i].rpt);
    end

    // 2: bounce then steady high from edge 9
    do_reset();
    q_prs.delete();
    for (int e = 1; e <= 24; e++) begin
      bif.btn_raw[0] = (e <= 8) ? pat[e-1] : 1'b1;
      step();
      if (bif.btn_press[0]) q_prs.push_back(e);
    end
    chk_int("t2_press_count", q_prs.size(), 1);
    chk_int("t2_press_edge", (q_prs.size() > 0) ? q_prs[0] : -1, 15);

    // 3: long hold, repeat schedule
    do_reset();
    q_prs.delete(); q_rep.delete();
    bif.btn_raw[0] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (bif.btn_press[0])  q_prs.push_back(e);
      if (bif.btn_repeat[0]) q_rep.push_back(e);
    end
    chk_int("t3_press_count", q_prs.size(), 1);
    chk_int("t3_rep_count", q_rep.size(), 5);
    for (int i = 0; i < 5; i++)
      chk_int("t3_rep_edge", (i < q_rep.size()) ? q_rep[i] : -1, exp_rep3[i]);

    // 4: two-cycle glitch low while held
    do_reset();
    q_prs.delete(); q_rep.delete();
    for (int e = 1; e <= 36; e++) begin
      bif.btn_raw[0] = (e == 13 || e == 14) ? 1'b0 : 1'b1;
      step();
      if (bif.btn_press[0])  q_prs.push_back(e);
      if (bif.btn_repeat[0]) q_rep.push_back(e);
      if (e >= 7) chk_int("t4_level_held", int'(bif.btn_level[0]), 1);
    end
    chk_int("t4_press_count", q_prs.size(), 1);
    chk_int("t4_rep_count", q_rep.size(), 3);
    for (int i = 0; i < 3; i++)
      chk_int("t4_rep_edge", (i < q_rep.size()) ? q_rep[i] : -1, exp_rep4[i]);

    // 5: reset during debounce with the button held, then during hold
    do_reset();
    q_prs.delete();
    bif.btn_raw[0] = 1'b1;
    repeat (4) step();
    Reset = 1'b1;
    #1;
    chk("t5_rst_level",  bif.btn_level,  '0);
    chk("t5_rst_press",  bif.btn_press,  '0);
    chk("t5_rst_repeat", bif.btn_repeat, '0);
    repeat (3) step();
    Reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (bif.btn_press[0]) q_prs.push_back(e);
    end
    chk_int("t5_press_count", q_prs.size(), 1);
    chk_int("t5_press_edge", (q_prs.size() > 0) ? q_prs[0] : -1, 7);
    chk_int("t5_level_before", int'(bif.btn_level[0]), 1);
    Reset = 1'b1;
    #1;
    chk_int("t5_level_async", int'(bif.btn_level[0]), 0);
    repeat (2) step();
    Reset = 1'b0;
    bif.btn_raw = '0;

    // 6: two buttons rising together
    do_reset();
    bif.btn_raw = NB'(3);
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("t6_press", bif.btn_press, (e == 7) ? NB'(3) : '0);
      chk("t6_level", bif.btn_level, (e >= 7) ? NB'(3) : '0);
    end

    // Randomised runs of bounces and holds on all buttons, occasional resets
    do_reset();
    for (int c = 0; c < NB; c++) r_left[c] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NB; c++) begin
        r_left[c]--;
        if (r_left[c] <= 0) begin
          bif.btn_raw[c] = ~bif.btn_raw[c];
          r_left[c] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3))
                                                 : int'($urandom_range(4, 40));
        end
      end
      if (!Reset && $urandom_range(0, 599) == 0) Reset = 1'b1;
      else if (Reset) Reset = 1'b0;
      step();
    end
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
